rtc_field_editor: RTL and testbench
===================================

Name: rtc_field_editor

Overview:
Parametrised BCD field editor for the RTC user interface. It captures a snapshot of N packed-BCD time or date fields and moves a cursor field-by-field on left/right buttons. Up/down buttons step the selected field with min/max wrap and hold-to-repeat. An optional date mode clamps the day field to the month length, leap-year aware. When editing ends it pulses a commit so the RTC write path can take the edited value.

Parameters:
NFIELDS, 3, number of 8-bit BCD fields (1..16); field 0 in bits [7:0].
FMAX, {8'h99,8'h12,8'h31}, packed per-field BCD maximum (default: year, month, day).
FMIN, {8'h00,8'h01,8'h01}, packed per-field BCD minimum.
DATE_MODE, 1, 1 = field0 is day, field1 is month, field2 is year 00-99 (meaning 2000-2099); day limit is dynamic.
REPEAT_DELAY, 25000000, clk cycles a button is held before the first auto-repeat.
REPEAT_RATE, 10000000, clk cycles between auto-repeats.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
en  in  1  edit enable; level.
load_data  in  8*NFIELDS  live RTC fields; sampled on edit entry.
bt_up  in  1  debounced, clk-synchronous button.
bt_down  in  1  as above.
bt_left  in  1  as above.
bt_right  in  1  as above.
edit_data  out  8*NFIELDS  working copy of the fields.
cursor  out  4  selected field index.
editing  out  1  high while in EDIT.
commit  out  1  one-cycle pulse when editing ends.

Behaviour:
- Reset (sync, overrides all): edit_data=0, cursor=0, editing=0, commit=0, FSM=IDLE, button history=0, repeat counter=0.
- FSM states IDLE, LOAD, EDIT.
  - IDLE: if en=1, go to LOAD.
  - LOAD (1 cycle): edit_data<=load_data, cursor<=0, button history<=current buttons, so buttons already held do not fire. Next state EDIT.
  - EDIT: editing=1. If en=0, go to IDLE and assert commit for exactly 1 cycle; edit_data holds its value afterwards.
- Press event: the button is 1 now and was 0 in the previous cycle (registered history).
- Cursor:
  - right press: cursor+1; NFIELDS-1 wraps to 0.
  - left press: cursor-1; 0 wraps to NFIELDS-1.
  - left and right pressed in the same cycle: cursor unchanged.
- Value (selected field v, with lo=FMIN[cursor] and hi=limit(cursor)):
  - up: if v>=hi then v<=lo, else v<=BCD(v+1). A units digit of 9 carries into tens.
  - down: if v<=lo then v<=hi, else v<=BCD(v-1). A units digit of 0 borrows, giving units 9.
  - up and down in the same cycle: no change; repeat counter cleared.
  - A value step and a cursor move in the same cycle: the step applies to the old cursor field, then the cursor moves.
  - Loaded out-of-range or non-BCD values are kept until the field is first stepped; they then wrap by the rules above.
- Auto-repeat:
  - While exactly one of up/down is held, a counter increments from the press.
  - At count REPEAT_DELAY the counter generates a step and reloads; a further step follows every REPEAT_RATE cycles.
  - Releasing the button, or pressing the other one, clears the counter.
  - Counter is 32 bits and saturates.
- Date mode (DATE_MODE=1):
  - limit(0) = days(month, year): 31, 30 for months 04/06/09/11, 28 for 02, or 29 for 02 when leap.
  - Leap year: tens digit even and units in {0,4,8}, or tens digit odd and units in {2,6}.
  - A day above the limit is clamped to the limit on the cycle after any month/year change, or after a load. The clamp has priority over a day step in that cycle.
  - Other fields use FMAX. When DATE_MODE=0, every field uses FMAX.
- en dropping during LOAD: LOAD completes, then EDIT exits next cycle with commit.
- Buttons are ignored in IDLE and LOAD.

Test Plan:
1. reset, en=1, load_data=24'h24_02_28, then up on field0 -> edit_data=24'h240229 (2024 leap); up again -> 24'h240201.
2. load 24'h23_03_31, right then down on field1 -> month 02, and the next cycle day clamps to 28: edit_data=24'h230228.
3. cursor=0 after load, left press -> cursor=2; three right presses -> cursor=2; left+right in the same cycle -> unchanged.
4. REPEAT_DELAY=4, REPEAT_RATE=2, field1=8'h01, hold up for 9 cycles -> 1 press step + repeats at cycles 4, 6, 8 -> 8'h05; hold down on 8'h01 -> wraps to 8'h12.
5. field2=8'h09 up -> 8'h10; field2=8'h00 down -> 8'h99; load non-BCD 8'hAA on field2 then up -> 8'h00.
6. en 1->0 in EDIT -> commit high exactly 1 cycle, editing=0, edit_data frozen; reset asserted mid-EDIT -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/rtc_field_editor.sv
// BCD field editor for the RTC user interface: snapshots N packed-BCD fields on entry,
// moves a cursor, steps fields with wrap and hold-to-repeat, and pulses commit on exit.
module rtc_field_editor #(
   parameter int                   NFIELDS      = 3,
   parameter logic [8*NFIELDS-1:0] FMAX         = 24'h99_12_31,
   parameter logic [8*NFIELDS-1:0] FMIN         = 24'h00_01_01,
   parameter bit                   DATE_MODE    = 1'b1,
   parameter int unsigned          REPEAT_DELAY = 25000000,
   parameter int unsigned          REPEAT_RATE  = 10000000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic [8*NFIELDS-1:0]   load_data,
   input  logic                   bt_up,
   input  logic                   bt_down,
   input  logic                   bt_left,
   input  logic                   bt_right,
   output logic [8*NFIELDS-1:0]   edit_data,
   output logic [3:0]             cursor,
   output logic                   editing,
   output logic                   commit
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EDIT} state_t;

   localparam bit          DATE_EN  = DATE_MODE && (NFIELDS >= 3);
   localparam logic [3:0]  LAST     = 4'(NFIELDS - 1);
   localparam logic [31:0] DELAY_C  = 32'(REPEAT_DELAY);
   localparam logic [31:0] RATE_C   = 32'(REPEAT_RATE);

   state_t                 r_state, w_state_nxt;
   logic [8*NFIELDS-1:0]   r_data, w_data_nxt;
   logic [3:0]             r_cursor, w_cursor_nxt;
   logic                   r_commit;
   logic [3:0]             r_btn_hist;
   logic [31:0]            r_rep_cnt;
   logic                   r_rep_phase;
   logic                   r_pend, w_pend_nxt;

   logic [3:0]             w_btn, w_press;
   logic                   w_edit, w_one_held, w_rep_fire;
   logic                   w_up_step, w_dn_step, w_clamp;
   logic [7:0]             w_day_lim, w_cur_val, w_lo, w_hi, w_step_val;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
      if (v >= hi)         return lo;
      if (v[3:0] >= 4'd9)  return {v[7:4] + 4'd1, 4'd0};
      return v + 8'd1;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
      if (v <= lo)         return hi;
      if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
      return v - 8'd1;
   endfunction

   // Day limit follows the month (field 1) and the 2000-2099 year (field 2).
   if (DATE_EN) begin : g_date
      logic [7:0] w_month, w_year;
      logic       w_leap;
      assign w_month = r_data[15:8];
      assign w_year  = r_data[23:16];
      assign w_leap  = w_year[4] ? (w_year[3:0] == 4'd2 || w_year[3:0] == 4'd6)
                                 : (w_year[3:0] == 4'd0 || w_year[3:0] == 4'd4 ||
                                    w_year[3:0] == 4'd8);
      always_comb begin
         case (w_month)
            8'h04, 8'h06, 8'h09, 8'h11: w_day_lim = 8'h30;
            8'h02:                      w_day_lim = w_leap ? 8'h29 : 8'h28;
            default:                    w_day_lim = 8'h31;
         endcase
      end
   end else begin : g_nodate
      assign w_day_lim = FMAX[7:0];
   end

   assign w_btn      = {bt_up, bt_down, bt_left, bt_right};
   assign w_press    = w_btn & ~r_btn_hist;
   assign w_edit     = (r_state == S_EDIT);
   assign w_one_held = bt_up ^ bt_down;
   assign w_rep_fire = w_edit && w_one_held &&
                       (r_rep_phase ? (r_rep_cnt == RATE_C) : (r_rep_cnt == DELAY_C));
   assign w_up_step  = w_edit && bt_up && !bt_down && (w_press[3] || w_rep_fire);
   assign w_dn_step  = w_edit && bt_down && !bt_up && (w_press[2] || w_rep_fire);
   assign w_clamp    = DATE_EN && w_edit && r_pend && (r_data[7:0] > w_day_lim);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (en) w_state_nxt = S_LOAD;
         S_LOAD:  w_state_nxt = S_EDIT;
         S_EDIT:  if (!en) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_data_nxt   = r_data;
      w_cursor_nxt = r_cursor;
      w_pend_nxt   = 1'b0;
      w_cur_val    = '0;
      w_lo         = '0;
      w_hi         = '0;
      for (int i = 0; i < NFIELDS; i++) begin
         if (r_cursor == 4'(i)) begin
            w_cur_val = r_data[8*i +: 8];
            w_lo      = FMIN[8*i +: 8];
            w_hi      = (DATE_EN && i == 0) ? w_day_lim : FMAX[8*i +: 8];
         end
      end
      w_step_val = w_up_step ? bcd_inc(w_cur_val, w_lo, w_hi) : bcd_dec(w_cur_val, w_lo, w_hi);

      case (r_state)
         S_LOAD: begin
            w_data_nxt   = load_data;
            w_cursor_nxt = '0;
            w_pend_nxt   = DATE_EN;
         end
         S_EDIT: begin
            if (w_up_step || w_dn_step) begin
               for (int i = 0; i < NFIELDS; i++)
                  if (r_cursor == 4'(i)) w_data_nxt[8*i +: 8] = w_step_val;
               w_pend_nxt = DATE_EN && (r_cursor == 4'd1 || r_cursor == 4'd2);
            end
            // Clamping the day wins over a day step in the same cycle.
            if (w_clamp) w_data_nxt[7:0] = w_day_lim;
            if (w_press[0] && !w_press[1])
               w_cursor_nxt = (r_cursor == LAST) ? 4'd0 : r_cursor + 4'd1;
            else if (w_press[1] && !w_press[0])
               w_cursor_nxt = (r_cursor == 4'd0) ? LAST : r_cursor - 4'd1;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous here.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_data      <= '0;
         r_cursor    <= '0;
         r_commit    <= 1'b0;
         r_btn_hist  <= '0;
         r_rep_cnt   <= '0;
         r_rep_phase <= 1'b0;
         r_pend      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_data     <= w_data_nxt;
         r_cursor   <= w_cursor_nxt;
         r_commit   <= w_edit && !en;
         r_btn_hist <= w_btn;
         r_pend     <= w_pend_nxt;
         if (!(w_edit && w_one_held)) begin
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
         end else if (w_rep_fire) begin
            r_rep_cnt   <= 32'd1;
            r_rep_phase <= 1'b1;
         end else if (r_rep_cnt != '1) begin
            r_rep_cnt   <= r_rep_cnt + 32'd1;
         end
      end
   end

   assign edit_data = r_data;
   assign cursor    = r_cursor;
   assign editing   = w_edit;
   assign commit    = r_commit;

endmodule

// File: tb/tb_rtc_field_editor.sv
// Directed bench for rtc_field_editor: a table of per-cycle vectors plus hand-written
// sequences for auto-repeat, commit timing, en drop during load and reset mid-edit.
module tb_rtc_field_editor;

   localparam logic [3:0] B0 = 4'b0000, UP = 4'b1000, DN = 4'b0100, L = 4'b0010, R = 4'b0001;

   typedef struct {
      string       name;
      logic        en;
      logic [23:0] ld;
      logic [3:0]  btn;
      logic [23:0] d;
      logic [3:0]  cur;
      logic        ed;
      logic        cm;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, en;
   logic [23:0] load_data;
   logic        bt_up, bt_down, bt_left, bt_right;
   logic [23:0] edit_data;
   logic [3:0]  cursor;
   logic        editing, commit;

   int   n_total = 0;
   int   n_bad   = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   rtc_field_editor #(
      .NFIELDS(3), .FMAX(24'h99_12_31), .FMIN(24'h00_01_01), .DATE_MODE(1'b1),
      .REPEAT_DELAY(4), .REPEAT_RATE(2)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .load_data(load_data),
      .bt_up(bt_up), .bt_down(bt_down), .bt_left(bt_left), .bt_right(bt_right),
      .edit_data(edit_data), .cursor(cursor), .editing(editing), .commit(commit)
   );

   task automatic drive(input logic e, input logic [23:0] ld, input logic [3:0] b);
      en = e;
      load_data = ld;
      {bt_up, bt_down, bt_left, bt_right} = b;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_out(input string name, input logic [23:0] d, input logic [3:0] c,
                             input logic ed, input logic cm);
      check({name, ".data"},    32'(edit_data), 32'(d));
      check({name, ".cursor"},  32'(cursor),    32'(c));
      check({name, ".editing"}, 32'(editing),   32'(ed));
      check({name, ".commit"},  32'(commit),    32'(cm));
   endtask

   task automatic add(input string n, input logic e, input logic [23:0] ld, input logic [3:0] b,
                      input logic [23:0] d, input logic [3:0] c, input logic ed, input logic cm);
      vec_t v;
      v = '{n, e, ld, b, d, c, ed, cm};
      vecs.push_back(v);
   endtask

   initial begin
      // leap-day step and day wrap
      add("idle2load",   1, 24'h240228, B0, 24'h000000, 0, 0, 0);
      add("load_a",      1, 24'h240228, B0, 24'h240228, 0, 1, 0);
      add("up_leap",     1, 24'h240228, UP, 24'h240229, 0, 1, 0);
      add("rel_a",       1, 24'h240228, B0, 24'h240229, 0, 1, 0);
      add("up_day_wrap", 1, 24'h240228, UP, 24'h240201, 0, 1, 0);
      add("rel_b",       1, 24'h240228, B0, 24'h240201, 0, 1, 0);
      add("exit_a",      0, 24'h240228, B0, 24'h240201, 0, 0, 1);
      add("idle_a",      0, 24'h230331, B0, 24'h240201, 0, 0, 0);
      // month change then day clamp
      add("enter_b",     1, 24'h230331, B0, 24'h240201, 0, 0, 0);
      add("load_b",      1, 24'h230331, B0, 24'h230331, 0, 1, 0);
      add("right_b",     1, 24'h230331, R,  24'h230331, 1, 1, 0);
      add("month_dn",    1, 24'h230331, DN, 24'h230231, 1, 1, 0);
      add("clamp28",     1, 24'h230331, B0, 24'h230228, 1, 1, 0);
      add("exit_b",      0, 24'h230331, B0, 24'h230228, 1, 0, 1);
      // cursor wrap
      add("enter_c",     1, 24'h230331, B0, 24'h230228, 1, 0, 0);
      add("load_c",      1, 24'h230331, B0, 24'h230331, 0, 1, 0);
      add("left_wrap",   1, 24'h230331, L,  24'h230331, 2, 1, 0);
      add("rel_c0",      1, 24'h230331, B0, 24'h230331, 2, 1, 0);
      add("right_wrap",  1, 24'h230331, R,  24'h230331, 0, 1, 0);
      add("rel_c1",      1, 24'h230331, B0, 24'h230331, 0, 1, 0);
      add("right_1",     1, 24'h230331, R,  24'h230331, 1, 1, 0);
      add("rel_c2",      1, 24'h230331, B0, 24'h230331, 1, 1, 0);
      add("right_2",     1, 24'h230331, R,  24'h230331, 2, 1, 0);
      add("rel_c3",      1, 24'h230331, B0, 24'h230331, 2, 1, 0);
      add("left_right",  1, 24'h230331, L|R, 24'h230331, 2, 1, 0);
      add("rel_c4",      1, 24'h230331, B0, 24'h230331, 2, 1, 0);
      add("exit_c",      0, 24'h230331, B0, 24'h230331, 2, 0, 1);
      // year BCD carry / borrow
      add("enter_d",     1, 24'h090115, B0, 24'h230331, 2, 0, 0);
      add("load_d",      1, 24'h090115, B0, 24'h090115, 0, 1, 0);
      add("left_d",      1, 24'h090115, L,  24'h090115, 2, 1, 0);
      add("rel_d0",      1, 24'h090115, B0, 24'h090115, 2, 1, 0);
      add("yr_carry",    1, 24'h090115, UP, 24'h100115, 2, 1, 0);
      add("rel_d1",      1, 24'h090115, B0, 24'h100115, 2, 1, 0);
      add("yr_borrow",   1, 24'h090115, DN, 24'h090115, 2, 1, 0);
      add("rel_d2",      1, 24'h090115, B0, 24'h090115, 2, 1, 0);
      add("exit_d",      0, 24'h090115, B0, 24'h090115, 2, 0, 1);
      // year wrap down
      add("enter_e",     1, 24'h000630, B0, 24'h090115, 2, 0, 0);
      add("load_e",      1, 24'h000630, B0, 24'h000630, 0, 1, 0);
      add("left_e",      1, 24'h000630, L,  24'h000630, 2, 1, 0);
      add("rel_e0",      1, 24'h000630, B0, 24'h000630, 2, 1, 0);
      add("yr_wrap_dn",  1, 24'h000630, DN, 24'h990630, 2, 1, 0);
      add("rel_e1",      1, 24'h000630, B0, 24'h990630, 2, 1, 0);
      add("exit_e",      0, 24'h000630, B0, 24'h990630, 2, 0, 1);
      // non-BCD year, clamp after load
      add("enter_f",     1, 24'hAA0229, B0, 24'h990630, 2, 0, 0);
      add("load_f",      1, 24'hAA0229, B0, 24'hAA0229, 0, 1, 0);
      add("clamp_load",  1, 24'hAA0229, L,  24'hAA0228, 2, 1, 0);
      add("rel_f0",      1, 24'hAA0229, B0, 24'hAA0228, 2, 1, 0);
      add("nonbcd_up",   1, 24'hAA0229, UP, 24'h000228, 2, 1, 0);
      add("rel_f1",      1, 24'hAA0229, B0, 24'h000228, 2, 1, 0);
      add("exit_f",      0, 24'h230431, B0, 24'h000228, 2, 0, 1);
      // clamp beats day step on the first edit cycle
      add("enter_g",     1, 24'h230431, B0, 24'h000228, 2, 0, 0);
      add("load_g",      1, 24'h230431, B0, 24'h230431, 0, 1, 0);
      add("clamp_prio",  1, 24'h230431, UP, 24'h230430, 0, 1, 0);
      add("rel_g",       1, 24'h230431, B0, 24'h230430, 0, 1, 0);

      reset = 1'b1;
      drive(0, 24'h123456, UP);
      drive(0, 24'h123456, UP);
      expect_out("reset", 24'h000000, 0, 0, 0);
      reset = 1'b0;
      drive(0, 24'h000000, B0);
      expect_out("post_reset", 24'h000000, 0, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].en, vecs[i].ld, vecs[i].btn);
         expect_out(vecs[i].name, vecs[i].d, vecs[i].cur, vecs[i].ed, vecs[i].cm);
      end

      // commit lasts one cycle, data frozen, buttons ignored in IDLE
      drive(0, 24'h000115, B0);
      expect_out("commit_hi", 24'h230430, 0, 0, 1);
      drive(0, 24'h000115, B0);
      expect_out("commit_lo", 24'h230430, 0, 0, 0);
      drive(0, 24'h000115, UP);
      expect_out("idle_btn", 24'h230430, 0, 0, 0);

      // hold up on month: press step plus repeats at hold cycles 4, 6, 8
      drive(1, 24'h000115, B0);
      drive(1, 24'h000115, B0);
      expect_out("load_rep", 24'h000115, 0, 1, 0);
      drive(1, 24'h000115, R);
      for (int k = 0; k < 9; k++) begin
         drive(1, 24'h000115, UP);
         if (k == 3) check("rep_before_delay", 32'(edit_data), 32'h000215);
         if (k == 4) check("rep_first",        32'(edit_data), 32'h000315);
      end
      check("rep_hold9", 32'(edit_data), 32'h000515);
      drive(1, 24'h000115, B0);
      expect_out("rep_release", 24'h000515, 1, 1, 0);

      // month down wraps 01 -> 12, then first repeat on hold cycle 4
      drive(0, 24'h000115, B0);
      drive(0, 24'h000115, B0);
      drive(1, 24'h000115, B0);
      drive(1, 24'h000115, B0);
      drive(1, 24'h000115, R);
      drive(1, 24'h000115, DN);
      check("month_wrap_dn", 32'(edit_data), 32'h001215);
      for (int k = 1; k < 4; k++) drive(1, 24'h000115, DN);
      check("dn_hold3", 32'(edit_data), 32'h001215);
      drive(1, 24'h000115, DN);
      check("dn_repeat", 32'(edit_data), 32'h001115);
      drive(1, 24'h000115, UP | DN);
      check("up_dn_same", 32'(edit_data), 32'h001115);

      // en dropped during LOAD: load completes, then exit with commit
      drive(0, 24'h240101, B0);
      drive(0, 24'h240101, B0);
      drive(1, 24'h240101, B0);
      drive(0, 24'h240101, B0);
      expect_out("en_drop_load", 24'h240101, 0, 1, 0);
      drive(0, 24'h240101, B0);
      expect_out("en_drop_exit", 24'h240101, 0, 0, 1);

      // reset in the middle of an edit
      drive(1, 24'h231231, B0);
      drive(1, 24'h231231, B0);
      drive(1, 24'h231231, R);
      expect_out("pre_reset", 24'h231231, 1, 1, 0);
      reset = 1'b1;
      drive(1, 24'h231231, UP);
      expect_out("reset_mid", 24'h000000, 0, 0, 0);
      reset = 1'b0;
      drive(0, 24'h231231, B0);
      expect_out("reset_after", 24'h000000, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
